// File: rtl/bus_pkg.sv
// Shared-bus op and controller-state encodings, common to the snoop bus
// controller and the CPU-side cache controllers.
package bus_pkg;

   typedef enum logic [1:0] {
      OP_RD_MISS = 2'b00,
      OP_WR_MISS = 2'b01,
      OP_INVAL   = 2'b10,
      OP_WBACK   = 2'b11
   } bus_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GRANT  = 3'd1,
      ST_SNOOP  = 3'd2,
      ST_MEM_WR = 3'd3,
      ST_MEM_RD = 3'd4,
      ST_RESP   = 3'd5
   } bus_state_e;

   function automatic logic op_is_miss(input bus_op_e op);
      return (op == OP_RD_MISS) || (op == OP_WR_MISS);
   endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: registered priority pointer, combinational one-hot grant.
// The pointer moves past the winner only when the bus controller confirms the grant.
module rr_arbiter #(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     req_i,
   input  logic             adv_i,
   input  logic [IDX_W-1:0] adv_idx_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   cand;
   logic             found;

   // Scan from the pointer upwards, wrapping, and take the first requester.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            found     = 1'b1;
            gnt_idx_o = cand[IDX_W-1:0];
         end
      end
      gnt_o[gnt_idx_o] = found;
   end

   assign ptr_d = (adv_idx_i == IDX_W'(N - 1)) ? '0 : adv_idx_i + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i)      ptr_q <= '0;
      else if (adv_i) ptr_q <= ptr_d;
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping shared-bus controller: round-robin grant, snoop broadcast, dirty-copy
// collection and word-addressed memory. Define CACHE_TO_CACHE_EN to forward dirty data.
module snoop_bus_ctrl
   import bus_pkg::*;
#(
   parameter int N_CPUS      = 2,
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [N_CPUS-1:0]        req_valid_i,
   input  logic [2*N_CPUS-1:0]      req_op_i,
   input  logic [ADDR_W*N_CPUS-1:0] req_addr_i,
   input  logic [DATA_W*N_CPUS-1:0] req_data_i,
   output logic [N_CPUS-1:0]        req_grant_o,
   output logic [N_CPUS-1:0]        resp_valid_o,
   output logic [DATA_W-1:0]        resp_data_o,
   output logic                     snoop_valid_o,
   output logic [1:0]               snoop_op_o,
   output logic [ADDR_W-1:0]        snoop_addr_o,
   output logic [N_CPUS-1:0]        snoop_src_o,
   input  logic [N_CPUS-1:0]        snoop_dirty_i,
   input  logic [DATA_W*N_CPUS-1:0] snoop_data_i,
   output logic                     busy_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int IDX_W = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   bus_state_e        state_q, state_d;
   logic [IDX_W-1:0]  win_q, win_d;
   logic [N_CPUS-1:0] win_oh_q, win_oh_d;
   bus_op_e           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;

   logic [N_CPUS-1:0] arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              snp_hit;
   logic [DATA_W-1:0] snp_word;

   rr_arbiter #(.N(N_CPUS)) u_arb (
      .clk_i     (clock_i),
      .rst_i     (reset_i),
      .req_i     (req_valid_i),
      .adv_i     (state_q == ST_GRANT),
      .adv_idx_i (win_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx)
   );

   // Dirty responders other than the requester; descending scan so the lowest index wins.
   always_comb begin
      snp_hit  = 1'b0;
      snp_word = '0;
      for (int i = N_CPUS - 1; i >= 0; i--) begin
         if (snoop_dirty_i[i] && !win_oh_q[i]) begin
            snp_hit  = 1'b1;
            snp_word = snoop_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      win_oh_d = win_oh_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) begin
               win_d    = arb_idx;
               win_oh_d = arb_gnt;
               op_d     = bus_op_e'(req_op_i[arb_idx*2 +: 2]);
               addr_d   = req_addr_i[arb_idx*ADDR_W +: ADDR_W];
               wdata_d  = req_data_i[arb_idx*DATA_W +: DATA_W];
               state_d  = ST_GRANT;
            end
         end
         ST_GRANT: state_d = ST_SNOOP;
         ST_SNOOP: begin
            cnt_d = CNT_LOAD;
            if (op_q == OP_INVAL) begin
               state_d = ST_RESP;
            end else if (op_q == OP_WBACK) begin
               state_d = ST_MEM_WR;
            end else if (snp_hit) begin
               wdata_d = snp_word;
`ifdef CACHE_TO_CACHE_EN
               rdata_d = snp_word;
`endif
               state_d = ST_MEM_WR;
            end else begin
               state_d = ST_MEM_RD;
            end
         end
         ST_MEM_WR: begin
            if (cnt_q == '0) begin
               mem_we = 1'b1;
               cnt_d  = CNT_LOAD;
`ifdef CACHE_TO_CACHE_EN
               state_d = ST_RESP;
`else
               // A miss only lands here after a dirty hit; refetch the freshly written word.
               state_d = op_is_miss(op_q) ? ST_MEM_RD : ST_RESP;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_MEM_RD: begin
            if (cnt_q == '0) begin
               rdata_d = mem_q[addr_q];
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         win_oh_q <= '0;
         op_q     <= OP_RD_MISS;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         win_oh_q <= win_oh_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign snoop_valid_o = (state_q == ST_GRANT);
   assign req_grant_o   = snoop_valid_o ? win_oh_q : '0;
   assign snoop_src_o   = req_grant_o;
   assign snoop_op_o    = snoop_valid_o ? op_q : 2'b00;
   assign snoop_addr_o  = snoop_valid_o ? addr_q : '0;
   assign resp_valid_o  = (state_q == ST_RESP) ? win_oh_q : '0;
   assign resp_data_o   = (state_q == ST_RESP && op_is_miss(op_q)) ? rdata_q : '0;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl against a transaction-level memory/arbitration model.
// Build with +define+CACHE_TO_CACHE_EN to check the forwarding variant.
module tb_snoop_bus_ctrl;
   localparam int N = 2, AW = 3, DW = 4, L = 2;
   localparam logic [1:0] RD = 2'b00, WR = 2'b01, INV = 2'b10, WB = 2'b11;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0, req_grant, resp_valid, snoop_src, snoop_dirty = '0;
   logic [2*N-1:0] req_op = '0;
   logic [AW*N-1:0] req_addr = '0;
   logic [DW*N-1:0] req_data = '0, snoop_data = '0;
   logic [DW-1:0]  resp_data;
   logic           snoop_valid, busy;
   logic [1:0]     snoop_op;
   logic [AW-1:0]  snoop_addr;

   int n_pass = 0, n_total = 0;
   logic [DW-1:0] mem_m [2**AW];
   int ptr_m = 0;

   always #5 clock = ~clock;

   snoop_bus_ctrl #(.N_CPUS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
      .clock_i(clock), .reset_i(reset),
      .req_valid_i(req_valid), .req_op_i(req_op), .req_addr_i(req_addr), .req_data_i(req_data),
      .req_grant_o(req_grant), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
      .snoop_valid_o(snoop_valid), .snoop_op_o(snoop_op), .snoop_addr_o(snoop_addr),
      .snoop_src_o(snoop_src), .snoop_dirty_i(snoop_dirty), .snoop_data_i(snoop_data),
      .busy_o(busy)
   );

   task automatic model_clear();
      for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
      ptr_m = 0;
   endtask

   // Transaction-level model: expected fill data and grant->resp latency; updates memory.
   task automatic model_txn(input int cpu, input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [N-1:0] dmask,
                            input logic [DW*N-1:0] ddata, output logic [DW-1:0] exp_d, output int lat);
      int src = -1;
      for (int i = 0; i < N; i++) if (src < 0 && i != cpu && dmask[i]) src = i;
      exp_d = '0;
      if (op == INV) lat = 2;
      else if (op == WB) begin
         lat = 2 + L;
         mem_m[addr] = wd;
      end else if (src >= 0) begin
         exp_d = ddata[src*DW +: DW];
         mem_m[addr] = exp_d;
`ifdef CACHE_TO_CACHE_EN
         lat = 2 + L;
`else
         lat = 2 + 2*L;
`endif
      end else begin
         exp_d = mem_m[addr];
         lat = 2 + L;
      end
      ptr_m = (cpu + 1) % N;
   endtask

   task automatic run_txn(input string nm, input int cpu, input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [N-1:0] dmask, input logic [DW*N-1:0] ddata);
      logic [DW-1:0] exp_d;
      logic [N-1:0]  oh;
      int lat, cyc;
      bit got;
      oh = N'(1) << cpu;
      req_valid[cpu] = 1'b1;
      req_op[2*cpu +: 2] = op;
      req_addr[AW*cpu +: AW] = addr;
      req_data[DW*cpu +: DW] = wd;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         if (req_grant != '0) begin got = 1; break; end
      end
      n_total++;
      if (!got || req_grant !== oh) $display("FAIL %s grant: got %b want %b (seen=%0d)", nm, req_grant, oh, got);
      else n_pass++;
      if (!got) begin req_valid[cpu] = 1'b0; return; end
      n_total++;
      if ({snoop_valid, snoop_op, snoop_addr, snoop_src} !== {1'b1, op, addr, oh})
         $display("FAIL %s snoop: got v%b op%b a%0d src%b want op%b a%0d src%b", nm,
                  snoop_valid, snoop_op, snoop_addr, snoop_src, op, addr, oh);
      else n_pass++;
      req_valid[cpu] = 1'b0;
      snoop_dirty = dmask;
      snoop_data = ddata;
      model_txn(cpu, op, addr, wd, dmask, ddata, exp_d, lat);
      got = 0; cyc = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         cyc++;
         if (cyc == 2) begin snoop_dirty = '0; snoop_data = '0; end
         if (resp_valid != '0) begin got = 1; break; end
      end
      n_total++;
      if (!got || resp_valid !== oh || cyc != lat)
         $display("FAIL %s resp: got %b after %0d want %b after %0d", nm, resp_valid, cyc, oh, lat);
      else n_pass++;
      if (op == RD || op == WR) begin
         n_total++;
         if (resp_data !== exp_d) $display("FAIL %s data: got %h want %h", nm, resp_data, exp_d);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_total++;
      if ({busy, req_grant, resp_valid, resp_data, snoop_valid, snoop_op, snoop_addr, snoop_src} !== '0)
         $display("FAIL reset outputs: busy%b gnt%b resp%b data%h sv%b", busy, req_grant, resp_valid, resp_data, snoop_valid);
      else n_pass++;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_rd_miss();
      run_txn("rd_miss5", 0, RD, 3'd5, '0, '0, '0);
   endtask

   task automatic test_wback_readback();
      run_txn("wback3", 1, WB, 3'd3, 4'hA, '0, '0);
      run_txn("rd_back3", 0, RD, 3'd3, '0, '0, '0);
   endtask

   task automatic test_fairness();
      logic [1:0]    op [N];
      logic [AW-1:0] ad [N];
      logic [DW-1:0] wd [N];
      int cnt [N];
      logic [DW-1:0] ed;
      logic [N-1:0]  oh;
      int w, lat, cyc;
      bit got;
      for (int c = 0; c < N; c++) begin
         op[c] = 2'($urandom_range(0, 3)); ad[c] = AW'($urandom); wd[c] = DW'($urandom); cnt[c] = 0;
         req_valid[c] = 1'b1; req_op[2*c +: 2] = op[c]; req_addr[AW*c +: AW] = ad[c]; req_data[DW*c +: DW] = wd[c];
      end
      for (int k = 0; k < 6; k++) begin
         w = -1;
         for (int i = 0; i < N; i++) if (w < 0 && req_valid[(ptr_m + i) % N]) w = (ptr_m + i) % N;
         oh = N'(1) << w;
         got = 0;
         for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (req_grant != '0) begin got = 1; break; end
         end
         n_total++;
         if (!got || req_grant !== oh) $display("FAIL rr_order%0d: got %b want %b", k, req_grant, oh);
         else n_pass++;
         if (!got) break;
         req_valid[w] = 1'b0;
         model_txn(w, op[w], ad[w], wd[w], '0, '0, ed, lat);
         got = 0; cyc = 0;
         for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            cyc++;
            if (resp_valid != '0) begin got = 1; break; end
         end
         n_total++;
         if (!got || resp_valid !== oh || cyc != lat || ((op[w] == RD || op[w] == WR) && resp_data !== ed))
            $display("FAIL rr_resp%0d: got %b d%h after %0d want %b d%h after %0d", k, resp_valid, resp_data, cyc, oh, ed, lat);
         else n_pass++;
         cnt[w]++;
         if (k < 5) begin
            op[w] = 2'($urandom_range(0, 3)); ad[w] = AW'($urandom); wd[w] = DW'($urandom);
            req_valid[w] = 1'b1; req_op[2*w +: 2] = op[w]; req_addr[AW*w +: AW] = ad[w]; req_data[DW*w +: DW] = wd[w];
         end else begin
            req_valid = '0;
         end
      end
      n_total++;
      if (cnt[0] != 3 || cnt[1] != 3) $display("FAIL rr_share: got %0d/%0d want 3/3", cnt[0], cnt[1]);
      else n_pass++;
   endtask

   task automatic test_dirty_fill();
      run_txn("dirty_wr2", 0, WR, 3'd2, '0, 2'b10, 8'h70);
      run_txn("self_dirty_rd2", 1, RD, 3'd2, '0, 2'b10, 8'h90);
   endtask

   task automatic test_inval();
      run_txn("inval6", 1, INV, 3'd6, 4'hF, 2'b01, 8'h05);
      run_txn("rd_after_inval6", 0, RD, 3'd6, '0, '0, '0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 16; k++)
         run_txn("random", int'($urandom_range(0, N-1)), 2'($urandom_range(0, 3)), AW'($urandom),
                 DW'($urandom), N'($urandom), (DW*N)'($urandom));
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      run_txn("pre_wb3", 0, WB, 3'd3, 4'hC, '0, '0);
      req_valid[0] = 1'b1; req_op[1:0] = RD; req_addr[AW-1:0] = 3'd3;
      repeat (3) begin @(posedge clock); #1; end
      req_valid[0] = 1'b0;
      @(posedge clock); #1;
      n_total++;
      if (busy !== 1'b1 || resp_valid !== '0) $display("FAIL mid_busy: got busy%b resp%b want 1/00", busy, resp_valid);
      else n_pass++;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      n_total++;
      if (busy !== 1'b0 || resp_valid !== '0) $display("FAIL rst_abort: got busy%b resp%b want 0/00", busy, resp_valid);
      else n_pass++;
      model_clear();
      for (int i = 0; i < L + 3; i++) begin
         @(posedge clock); #1;
         if (resp_valid != '0 || busy) seen = 1;
      end
      n_total++;
      if (seen) $display("FAIL rst_quiet: got activity after reset want none");
      else n_pass++;
      run_txn("post_rst_rd3", 1, RD, 3'd3, '0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_rd_miss();
      test_wback_readback();
      test_fairness();
      test_dirty_fill();
      test_inval();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
